// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD arbiter and the GCD top: state encoding
// of the arbiter FSM and the default operand/result width.
package gcd_pkg;

  localparam int GCD_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    BYPASS = 3'd3,
    RESP   = 3'd4
  } gcd_arb_state_e;

endpackage

// File: rtl/gcd_rr_pick.sv
// Combinational round-robin picker: returns the first set request bit found
// when searching upward from ptr with wrap-around.
module gcd_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            valid,
  output logic [IDW-1:0]  id
);

  localparam logic [IDW:0] NREQ_W = (IDW + 1)'(NREQ);

  function automatic logic [IDW-1:0] rot_idx(input logic [IDW-1:0] base, input int off);
    logic [IDW:0] sum;
    sum = {1'b0, base} + (IDW + 1)'(off);
    if (sum >= NREQ_W) sum = sum - NREQ_W;
    return sum[IDW-1:0];
  endfunction

  // Scan offsets from farthest to nearest so the closest set bit to ptr wins
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[rot_idx(ptr, i)]) begin
        valid = 1'b1;
        id    = rot_idx(ptr, i);
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing one GCD unit between NREQ requesters.
// Captures the winner's operands, starts the GCD, waits for its valid and
// returns the tagged result. Zero operands bypass the GCD unit entirely.
// Optional watchdog on the WAIT state enabled by GCD_ARB_TIMEOUT_EN.
module gcd_arbiter
  import gcd_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = GCD_W,
  parameter int TMO  = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*W-1:0]        req_a,
  input  logic [NREQ*W-1:0]        req_b,
  output logic [NREQ-1:0]          grant,
  output logic                     done,
  output logic [$clog2(NREQ)-1:0]  done_id,
  output logic [W-1:0]             result,
  output logic                     err,
  output logic                     busy,
  output logic                     gcd_start,
  output logic [W-1:0]             gcd_a,
  output logic [W-1:0]             gcd_b,
  input  logic                     gcd_valid,
  input  logic [W-1:0]             gcd_result
);

  localparam int IDW = $clog2(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  gcd_arb_state_e state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [W-1:0]    byp_q, byp_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            done_q, done_d;
  logic [IDW-1:0]  done_id_q, done_id_d;
  logic [W-1:0]    result_q, result_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            start_q, start_d;
  logic [W-1:0]    gcd_a_q, gcd_a_d;
  logic [W-1:0]    gcd_b_q, gcd_b_d;
`ifdef GCD_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_W = 16'(TMO);
  logic [15:0]     cnt_q, cnt_d;
`endif

  logic            pick_valid;
  logic [IDW-1:0]  pick_id;
  logic [W-1:0]    a_arr [NREQ];
  logic [W-1:0]    b_arr [NREQ];
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*W +: W];
    assign b_arr[g] = req_b[g*W +: W];
  end

  assign sel_a = a_arr[pick_id];
  assign sel_b = b_arr[pick_id];

  gcd_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .id    (pick_id)
  );

  // Next-state and registered-output logic; pulses default low, data holds
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    byp_d     = byp_q;
    grant_d   = '0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    result_d  = result_q;
    err_d     = err_q;
    start_d   = 1'b0;
    gcd_a_d   = gcd_a_q;
    gcd_b_d   = gcd_b_q;
`ifdef GCD_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          id_d             = pick_id;
          grant_d[pick_id] = 1'b1;
          if (sel_a == '0 || sel_b == '0) begin
            byp_d   = sel_a | sel_b;
            state_d = BYPASS;
          end else begin
            gcd_a_d = sel_a;
            gcd_b_d = sel_b;
            start_d = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef GCD_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (gcd_valid) begin
          result_d  = gcd_result;
          err_d     = 1'b0;
          done_d    = 1'b1;
          done_id_d = id_q;
          state_d   = RESP;
        end
`ifdef GCD_ARB_TIMEOUT_EN
        else if (cnt_q + 16'd1 == TMO_W) begin
          result_d  = '0;
          err_d     = 1'b1;
          done_d    = 1'b1;
          done_id_d = id_q;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      BYPASS: begin
        result_d  = byp_q;
        err_d     = 1'b0;
        done_d    = 1'b1;
        done_id_d = id_q;
        state_d   = RESP;
      end
      RESP: begin
        ptr_d   = (id_q == LAST_ID) ? '0 : id_q + 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      byp_q     <= '0;
      grant_q   <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      gcd_a_q   <= '0;
      gcd_b_q   <= '0;
`ifdef GCD_ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      byp_q     <= byp_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      result_q  <= result_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      start_q   <= start_d;
      gcd_a_q   <= gcd_a_d;
      gcd_b_q   <= gcd_b_d;
`ifdef GCD_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign result    = result_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign gcd_start = start_q;
  assign gcd_a     = gcd_a_q;
  assign gcd_b     = gcd_b_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed testbench for gcd_arbiter with a behavioural GCD responder.
// Watchdog-expiry vectors are compiled in when GCD_ARB_TIMEOUT_EN is defined.
module tb_gcd_arbiter;
  import gcd_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = GCD_W;
  localparam int IDW  = $clog2(NREQ);

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   grant;
  logic              done;
  logic [IDW-1:0]    done_id;
  logic [W-1:0]      result;
  logic              err;
  logic              busy;
  logic              gcd_start;
  logic [W-1:0]      gcd_a;
  logic [W-1:0]      gcd_b;
  logic              gcd_valid;
  logic [W-1:0]      gcd_result;

  int vectors    = 0;
  int miscompares = 0;
  int starts     = 0;
  int dones      = 0;
  int multiGrant = 0;
  int respLat    = 3;
  bit respEn     = 1'b1;
  int countdown  = 0;
  logic [W-1:0] ra, rb;

  gcd_arbiter #(
    .NREQ (NREQ),
    .W    (W),
    .TMO  (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_a      (req_a),
    .req_b      (req_b),
    .grant      (grant),
    .done       (done),
    .done_id    (done_id),
    .result     (result),
    .err        (err),
    .busy       (busy),
    .gcd_start  (gcd_start),
    .gcd_a      (gcd_a),
    .gcd_b      (gcd_b),
    .gcd_valid  (gcd_valid),
    .gcd_result (gcd_result)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] time limit");
  end

  function automatic logic [W-1:0] gcdModel(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] a, b, t;
    a = x;
    b = y;
    while (b != '0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Behavioural GCD unit: answers respLat negedges after seeing gcd_start
  initial begin
    gcd_valid  = 1'b0;
    gcd_result = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        countdown = 0;
        if (respEn) gcd_valid = 1'b0;
      end else if (respEn) begin
        gcd_valid = 1'b0;
        if (gcd_start) begin
          ra = gcd_a;
          rb = gcd_b;
          countdown = respLat;
        end else if (countdown > 0) begin
          countdown--;
          if (countdown == 0) begin
            gcd_valid  = 1'b1;
            gcd_result = gcdModel(ra, rb);
          end
        end
      end
    end
  end

  // Event monitor sampled on the inactive edge
  always @(negedge clk) begin
    if (gcd_start) starts++;
    if (done) dones++;
    if ($countones(grant) > 1) multiGrant++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, observed, observed, expected, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [W-1:0] a, input logic [W-1:0] b);
    req = r;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
    end
  endtask

  task automatic waitDone(input string tag, input int maxCycles, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!done && cycles < maxCycles);
    if (!done) checkOutput({tag, "_done_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic waitGrant(input string tag, input int maxCycles);
    int cycles;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (grant == '0 && cycles < maxCycles);
    if (grant == '0) checkOutput({tag, "_grant_timeout"}, 32'(grant), 32'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ctrl"}, 32'({grant, done, done_id, err, busy, gcd_start}), 32'd0);
    checkOutput({tag, "_data"}, 32'({result, gcd_a, gcd_b}), 32'd0);
  endtask

  initial begin
    int c;
    int startsBefore;
    int donesAtReset;
    int expId;

    rst = 1'b1;
    applyStimulus('0, '0, '0);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    checkResetOutputs("reset_init");
    rst = 1'b1;
    @(negedge clk);

    // Single job through the GCD unit: gcd(48,18) = 6
    applyStimulus(4'b0001, 8'd48, 8'd18);
    @(negedge clk);
    checkOutput("single_grant", 32'(grant), 32'b0001);
    checkOutput("single_start", 32'(gcd_start), 32'd1);
    checkOutput("single_gcd_a", 32'(gcd_a), 32'd48);
    checkOutput("single_gcd_b", 32'(gcd_b), 32'd18);
    checkOutput("single_busy", 32'(busy), 32'd1);
    applyStimulus('0, '0, '0);
    waitDone("single", 40, c);
    checkOutput("single_id", 32'(done_id), 32'd0);
    checkOutput("single_result", 32'(result), 32'd6);
    checkOutput("single_err", 32'(err), 32'd0);
    @(negedge clk);
    checkOutput("single_busy_after", 32'(busy), 32'd0);
    checkOutput("single_done_pulse", 32'(done), 32'd0);
    checkOutput("single_gcd_a_hold", 32'(gcd_a), 32'd48);
    checkOutput("single_start_count", 32'(starts), 32'd1);

    // Bypass path: sample cycle, BYPASS, then done in RESP
    startsBefore = starts;
    applyStimulus(4'b0100, 8'd0, 8'd35);
    @(negedge clk);
    checkOutput("bypass_grant", 32'(grant), 32'b0100);
    checkOutput("bypass_no_start", 32'(gcd_start), 32'd0);
    applyStimulus('0, '0, '0);
    waitDone("bypass", 5, c);
    checkOutput("bypass_latency", 32'(c), 32'd1);
    checkOutput("bypass_id", 32'(done_id), 32'd2);
    checkOutput("bypass_result", 32'(result), 32'd35);
    checkOutput("bypass_err", 32'(err), 32'd0);
    @(negedge clk);
    applyStimulus(4'b0100, 8'd0, 8'd0);
    @(negedge clk);
    applyStimulus('0, '0, '0);
    waitDone("bypass00", 5, c);
    checkOutput("bypass00_id", 32'(done_id), 32'd2);
    checkOutput("bypass00_result", 32'(result), 32'd0);
    @(negedge clk);
    checkOutput("bypass_start_count", 32'(starts - startsBefore), 32'd0);

    // Contention: all four held, pointer restarted at 0 by a reset pulse
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    startsBefore = starts;
    applyStimulus(4'b1111, 8'd12, 8'd8);
    for (int k = 0; k < 5; k++) begin
      expId = k % NREQ;
      waitGrant("cont", 20);
      checkOutput($sformatf("cont_grant%0d", k), 32'(grant), 32'(1) << expId);
      waitDone($sformatf("cont%0d", k), 40, c);
      checkOutput($sformatf("cont_id%0d", k), 32'(done_id), 32'(expId));
      checkOutput($sformatf("cont_result%0d", k), 32'(result), 32'd4);
    end
    applyStimulus('0, '0, '0);
    repeat (2) @(negedge clk);
    checkOutput("cont_busy_after", 32'(busy), 32'd0);
    checkOutput("cont_multi_grant", 32'(multiGrant), 32'd0);
    checkOutput("cont_start_count", 32'(starts - startsBefore), 32'd5);

    // Reset in the middle of WAIT drops the job without a done pulse
    respLat = 20;
    applyStimulus(4'b0010, 8'd21, 8'd14);
    @(negedge clk);
    checkOutput("midrst_grant", 32'(grant), 32'b0010);
    applyStimulus('0, '0, '0);
    repeat (2) @(negedge clk);
    checkOutput("midrst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    checkResetOutputs("midrst_async");
    donesAtReset = dones;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    respLat = 3;
    @(negedge clk);
    applyStimulus(4'b0010, 8'd21, 8'd14);
    @(negedge clk);
    checkOutput("midrst_regrant", 32'(grant), 32'b0010);
    applyStimulus('0, '0, '0);
    waitDone("midrst", 40, c);
    checkOutput("midrst_id", 32'(done_id), 32'd1);
    checkOutput("midrst_result", 32'(result), 32'd7);
    @(negedge clk);
    checkOutput("midrst_done_count", 32'(dones - donesAtReset), 32'd1);

    // Stale valid during ISSUE must be ignored
    respEn = 1'b0;
    gcd_valid = 1'b0;
    applyStimulus(4'b1000, 8'd9, 8'd6);
    @(negedge clk);
    checkOutput("stale_grant", 32'(grant), 32'b1000);
    checkOutput("stale_start", 32'(gcd_start), 32'd1);
    applyStimulus('0, '0, '0);
    gcd_valid  = 1'b1;
    gcd_result = 8'd99;
    @(negedge clk);
    gcd_valid = 1'b0;
    checkOutput("stale_no_done1", 32'(done), 32'd0);
    checkOutput("stale_busy", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("stale_no_done2", 32'(done), 32'd0);
    gcd_valid  = 1'b1;
    gcd_result = 8'd3;
    waitDone("stale", 5, c);
    gcd_valid = 1'b0;
    checkOutput("stale_latency", 32'(c), 32'd1);
    checkOutput("stale_id", 32'(done_id), 32'd3);
    checkOutput("stale_result", 32'(result), 32'd3);
    @(negedge clk);

`ifdef GCD_ARB_TIMEOUT_EN
    // Watchdog: ten WAIT cycles without valid end in an error response
    applyStimulus(4'b0001, 8'd10, 8'd4);
    @(negedge clk);
    checkOutput("tmo_start", 32'(gcd_start), 32'd1);
    applyStimulus('0, '0, '0);
    waitDone("tmo", 20, c);
    checkOutput("tmo_latency", 32'(c), 32'd11);
    checkOutput("tmo_err", 32'(err), 32'd1);
    checkOutput("tmo_result", 32'(result), 32'd0);
    checkOutput("tmo_id", 32'(done_id), 32'd0);
    @(negedge clk);
    // Valid arriving on the expiry cycle wins over the watchdog
    applyStimulus(4'b0001, 8'd10, 8'd4);
    @(negedge clk);
    applyStimulus('0, '0, '0);
    repeat (10) @(negedge clk);
    checkOutput("tmo_race_no_done", 32'(done), 32'd0);
    gcd_valid  = 1'b1;
    gcd_result = 8'd2;
    @(negedge clk);
    gcd_valid = 1'b0;
    checkOutput("tmo_race_done", 32'(done), 32'd1);
    checkOutput("tmo_race_err", 32'(err), 32'd0);
    checkOutput("tmo_race_result", 32'(result), 32'd2);
    @(negedge clk);
`endif

    respEn = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
